// File: rtl/disp_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : disp_wr_arbiter
// Purpose  : Shares the debug-display register-file write port among N_REQ
//            producers. Round-robin arbitration with burst lock. The current
//            owner keeps the port until it presents a last beat, has moved
//            MAX_BURST beats, or has left its valid low for RELEASE_CYCLES
//            consecutive cycles. The write strobe, address and data are
//            registered and drive the display register file directly.
// Ports    : clk        - system clock
//            n_rst      - asynchronous active-low reset
//            req_valid  - per-requester beat valid
//            req_last   - per-requester final beat marker (qualified by valid)
//            req_addr   - packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//            req_data   - packed data, requester i at [i*DATA_W +: DATA_W]
//            req_ready  - per-requester beat accept (one-hot while granted)
//            load       - one-cycle write strobe to the register file
//            addr/data  - write address/data, valid with load
//            grant_id   - current (or most recent) owner index
//            busy       - high while a requester holds the grant
// Revision : 1.0 - initial release
// ============================================================================
module disp_wr_arbiter #(
  parameter int N_REQ          = 4,
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int MAX_BURST      = 8,
  parameter int RELEASE_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ-1:0]           req_last,
  input  logic [N_REQ*ADDR_W-1:0]    req_addr,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       load,
  output logic [ADDR_W-1:0]          addr,
  output logic [DATA_W-1:0]          data,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy
);

  localparam int c_ID_W   = $clog2(N_REQ);
  localparam int c_BEAT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int c_IDLE_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;

  localparam logic [c_BEAT_W-1:0] c_BEAT_MAX = c_BEAT_W'(MAX_BURST - 1);
  localparam logic [c_IDLE_W-1:0] c_IDLE_MAX = c_IDLE_W'(RELEASE_CYCLES - 1);
  localparam logic [c_ID_W-1:0]   c_ID_LAST  = c_ID_W'(N_REQ - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t              state_q,    state_d;
  logic [c_ID_W-1:0]   ptr_q,      ptr_d;
  logic [c_ID_W-1:0]   grant_id_q, grant_id_d;
  logic [c_BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [c_IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic                load_q,     load_d;
  logic [ADDR_W-1:0]   addr_q,     addr_d;
  logic [DATA_W-1:0]   data_q,     data_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic                w_win_found;
  logic [c_ID_W-1:0]   w_win_idx;
  logic [c_ID_W-1:0]   w_cand;
  logic                w_own_valid;
  logic                w_own_last;
  logic [ADDR_W-1:0]   w_own_addr;
  logic [DATA_W-1:0]   w_own_data;
  logic                w_xfer;
  logic                w_release;
  logic [c_ID_W-1:0]   w_next_ptr;

  // Round-robin winner: first valid requester starting at ptr and wrapping.
  // The modulo keeps the candidate in range for non-power-of-two N_REQ.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    w_cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = c_ID_W'((int'(ptr_q) + k) % N_REQ);
      if (!w_win_found && req_valid[w_cand]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_cand;
      end
    end
  end

  // Owner-side signals selected by the registered grant index.
  always_comb begin
    w_own_valid = 1'b0;
    w_own_last  = 1'b0;
    w_own_addr  = '0;
    w_own_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id_q == c_ID_W'(i)) begin
        w_own_valid = req_valid[i];
        w_own_last  = req_last[i];
        w_own_addr  = req_addr[i*ADDR_W +: ADDR_W];
        w_own_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Ready comes purely from registered state so there is no combinational
  // path from any req_valid back to req_ready.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
      assign req_ready[gi] = (state_q == ST_GRANT) && (grant_id_q == c_ID_W'(gi));
    end
  endgenerate

  assign w_xfer     = (state_q == ST_GRANT) && w_own_valid;
  assign w_next_ptr = (grant_id_q == c_ID_LAST) ? '0 : grant_id_q + c_ID_W'(1);

  // --------------------------------------------------------------------------
  // Next-state and datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    beat_cnt_d = beat_cnt_q;
    idle_cnt_d = idle_cnt_q;
    load_d     = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    w_release  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (w_win_found) begin
          state_d    = ST_GRANT;
          grant_id_d = w_win_idx;
          beat_cnt_d = '0;
          idle_cnt_d = '0;
        end
      end

      ST_GRANT: begin
        if (w_xfer) begin
          load_d     = 1'b1;
          addr_d     = w_own_addr;
          data_d     = w_own_data;
          idle_cnt_d = '0;
          // Counter never reaches MAX_BURST: the release below clears it
          // on the beat that would take it past MAX_BURST-1.
          beat_cnt_d = beat_cnt_q + c_BEAT_W'(1);
          if (w_own_last || (beat_cnt_q == c_BEAT_MAX)) begin
            w_release = 1'b1;
          end
        end else begin
          idle_cnt_d = idle_cnt_q + c_IDLE_W'(1);
          if (idle_cnt_q == c_IDLE_MAX) begin
            w_release = 1'b1;
          end
        end

        if (w_release) begin
          state_d    = ST_IDLE;
          ptr_d      = w_next_ptr;
          beat_cnt_d = '0;
          idle_cnt_d = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
      idle_cnt_q <= '0;
      load_q     <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      load_q     <= load_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  assign load     = load_q;
  assign addr     = addr_q;
  assign data     = data_q;
  assign grant_id = grant_id_q;
  assign busy     = (state_q == ST_GRANT);

endmodule
`default_nettype wire

// File: tb/tb_disp_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_disp_wr_arbiter
// Purpose  : Scoreboard bench for disp_wr_arbiter. Directed per-requester
//            beat streams drive the DUT; hand-computed write events
//            (cycle, addr, data, owner) are queued and a negedge monitor
//            compares each load strobe against the head of the queue.
//            A second instance (N_REQ=2, MAX_BURST=1) reruns the
//            arbitration patterns while the first is held in reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_disp_wr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic [3:0]  drv_valid, drv_last;
  logic [31:0] drv_addr, drv_data;

  logic [3:0]  ready_a;
  logic        load_a, busy_a;
  logic [7:0]  addr_a, data_a;
  logic [1:0]  gid_a;

  logic [1:0]  ready_b;
  logic        load_b, busy_b;
  logic [7:0]  addr_b, data_b;
  logic [0:0]  gid_b;

  disp_wr_arbiter #(
    .N_REQ(4), .ADDR_W(8), .DATA_W(8), .MAX_BURST(8), .RELEASE_CYCLES(4)
  ) u_dut_a (
    .clk(clk), .n_rst(rst_a),
    .req_valid(drv_valid), .req_last(drv_last),
    .req_addr(drv_addr), .req_data(drv_data),
    .req_ready(ready_a), .load(load_a), .addr(addr_a), .data(data_a),
    .grant_id(gid_a), .busy(busy_a)
  );

  disp_wr_arbiter #(
    .N_REQ(2), .ADDR_W(8), .DATA_W(8), .MAX_BURST(1), .RELEASE_CYCLES(4)
  ) u_dut_b (
    .clk(clk), .n_rst(rst_b),
    .req_valid(drv_valid[1:0]), .req_last(drv_last[1:0]),
    .req_addr(drv_addr[15:0]), .req_data(drv_data[15:0]),
    .req_ready(ready_b), .load(load_b), .addr(addr_b), .data(data_b),
    .grant_id(gid_b), .busy(busy_b)
  );

  // Selected-instance view
  bit         sel = 1'b0;
  logic [3:0] ready_m;
  logic       load_m, busy_m;
  logic [7:0] addr_m, data_m;
  logic [1:0] gid_m;
  assign ready_m = sel ? {2'b00, ready_b} : ready_a;
  assign load_m  = sel ? load_b : load_a;
  assign busy_m  = sel ? busy_b : busy_a;
  assign addr_m  = sel ? addr_b : addr_a;
  assign data_m  = sel ? data_b : data_a;
  assign gid_m   = sel ? {1'b0, gid_b} : gid_a;

  int cyc = 0;
  int t0  = 0;
  int errors = 0;
  int checks = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard
  typedef struct { int c; int a; int d; int g; } exp_t;
  exp_t exp_q[$];

  task automatic push(input int c, input int a, input int d, input int g);
    exp_t e;
    e.c = c; e.a = a; e.d = d; e.g = g;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin : p_mon
    exp_t e;
    if (load_m) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_load: got cycle=%0d addr=%02h data=%02h gid=%0d, required no load",
                 cyc - t0, addr_m, data_m, gid_m);
      end else begin
        e = exp_q.pop_front();
        if (e.c != (cyc - t0) || e.a != int'(addr_m) || e.d != int'(data_m) || e.g != int'(gid_m)) begin
          errors++;
          $display("FAIL load: got cycle=%0d addr=%02h data=%02h gid=%0d, required cycle=%0d addr=%02h data=%02h gid=%0d",
                   cyc - t0, addr_m, data_m, gid_m, e.c, e.a, e.d, e.g);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic check_empty(input string name);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Per-requester beat streams
  logic [7:0] s_addr [0:3][0:15];
  logic [7:0] s_data [0:3][0:15];
  logic       s_last [0:3][0:15];
  int s_len   [0:3];
  int s_start [0:3];
  int s_idx   [0:3];

  // mode: 0 = no last, 1 = last on final beat, 2 = every beat last
  task automatic set_stream(input int i, input int len, input int start,
                            input int ba, input int bd, input int mode);
    for (int k = 0; k < len; k++) begin
      s_addr[i][k] = 8'(ba + k);
      s_data[i][k] = 8'(bd + k);
      s_last[i][k] = (mode == 2) || (mode == 1 && k == len - 1);
    end
    s_len[i]   = len;
    s_start[i] = start;
    s_idx[i]   = 0;
  endtask

  task automatic clear_streams();
    for (int i = 0; i < 4; i++) begin
      s_len[i] = 0; s_start[i] = 0; s_idx[i] = 0;
    end
  endtask

  task automatic apply();
    for (int i = 0; i < 4; i++) begin
      if ((cyc - t0) >= s_start[i] && s_idx[i] < s_len[i]) begin
        drv_valid[i]       = 1'b1;
        drv_last[i]        = s_last[i][s_idx[i]];
        drv_addr[i*8 +: 8] = s_addr[i][s_idx[i]];
        drv_data[i*8 +: 8] = s_data[i][s_idx[i]];
      end else begin
        drv_valid[i]       = 1'b0;
        drv_last[i]        = 1'b0;
        drv_addr[i*8 +: 8] = 8'h00;
        drv_data[i*8 +: 8] = 8'h00;
      end
    end
  endtask

  // One cycle: note accepted beats at negedge, advance streams after the edge.
  task automatic step();
    logic [3:0] acc;
    @(negedge clk);
    acc = drv_valid & ready_m;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (acc[i]) s_idx[i]++;
    apply();
  endtask

  task automatic run_to(input int n);
    while ((cyc - t0) < n) step();
  endtask

  task automatic start_test();
    @(posedge clk);
    #1;
    t0 = cyc;
    apply();
  endtask

  task automatic do_reset();
    clear_streams();
    apply();
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_load",  int'(load_m),  0);
    check("rst_busy",  int'(busy_m),  0);
    check("rst_ready", int'(ready_m), 0);
    check("rst_gid",   int'(gid_m),   0);
    check("rst_addr",  int'(addr_m),  0);
    check("rst_data",  int'(data_m),  0);
    if (sel) rst_b = 1'b1;
    else     rst_a = 1'b1;
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    drv_valid = '0; drv_last = '0; drv_addr = '0; drv_data = '0;
    clear_streams();

    // 1: single requester burst of three beats
    sel = 1'b0;
    do_reset();
    set_stream(0, 3, 0, 8'h00, 8'hA0, 1);
    push(2, 8'h00, 8'hA0, 0);
    push(3, 8'h01, 8'hA1, 0);
    push(4, 8'h02, 8'hA2, 0);
    start_test();
    run_to(1);
    check("t1_ready_c1", int'(ready_m), 1);
    check("t1_busy_c1",  int'(busy_m),  1);
    run_to(4);
    check("t1_ready_c4", int'(ready_m), 0);
    check("t1_busy_c4",  int'(busy_m),  0);
    run_to(12);
    check_empty("t1_drain");

    // 2: all four single-beat requesters, round-robin rotation
    do_reset();
    set_stream(0, 2, 0, 8'h00, 8'hA0, 2);
    set_stream(1, 1, 0, 8'h10, 8'hB0, 2);
    set_stream(2, 1, 0, 8'h20, 8'hC0, 2);
    set_stream(3, 1, 0, 8'h30, 8'hD0, 2);
    push(2,  8'h00, 8'hA0, 0);
    push(4,  8'h10, 8'hB0, 1);
    push(6,  8'h20, 8'hC0, 2);
    push(8,  8'h30, 8'hD0, 3);
    push(10, 8'h01, 8'hA1, 0);
    start_test();
    run_to(16);
    check_empty("t2_drain");

    // 3: MAX_BURST cap, waiting requester, then idle release of the resumer
    do_reset();
    set_stream(1, 10, 0, 8'h10, 8'hB0, 0);
    set_stream(2, 1,  0, 8'h20, 8'hC0, 1);
    for (int k = 0; k < 8; k++) push(2 + k, 8'h10 + k, 8'hB0 + k, 1);
    push(11, 8'h20, 8'hC0, 2);
    push(13, 8'h18, 8'hB8, 1);
    push(14, 8'h19, 8'hB9, 1);
    start_test();
    run_to(17);
    check("t3_busy_c17", int'(busy_m), 1);
    run_to(18);
    check("t3_busy_c18", int'(busy_m), 0);
    run_to(24);
    check_empty("t3_drain");

    // 4: owner goes quiet; released after RELEASE_CYCLES idle cycles
    do_reset();
    set_stream(0, 2, 0, 8'h00, 8'hA0, 0);
    set_stream(3, 1, 0, 8'h30, 8'hD0, 1);
    push(2, 8'h00, 8'hA0, 0);
    push(3, 8'h01, 8'hA1, 0);
    push(9, 8'h30, 8'hD0, 3);
    start_test();
    run_to(6);
    check("t4_busy_c6", int'(busy_m), 1);
    run_to(7);
    check("t4_busy_c7", int'(busy_m), 0);
    run_to(8);
    check("t4_ready_c8", int'(ready_m), 8);
    run_to(14);
    check_empty("t4_drain");

    // 5: reset mid-burst while a beat is being accepted
    do_reset();
    set_stream(0, 4, 0, 8'h00, 8'hA0, 1);
    start_test();
    run_to(2);
    check("t5_preload", int'(load_m), 1);
    #2;
    rst_a = 1'b0;
    #1;
    check("t5_rst_load",  int'(load_m),  0);
    check("t5_rst_busy",  int'(busy_m),  0);
    check("t5_rst_ready", int'(ready_m), 0);
    clear_streams();
    apply();
    step();
    step();
    rst_a = 1'b1;
    step();
    step();
    check("t5_noload", int'(load_m), 0);
    check("t5_idle",   int'(busy_m), 0);
    check_empty("t5_none");
    set_stream(0, 1, 0, 8'h00, 8'hA0, 1);
    set_stream(2, 1, 0, 8'h20, 8'hC0, 1);
    push(2, 8'h00, 8'hA0, 0);
    push(4, 8'h20, 8'hC0, 2);
    start_test();
    run_to(10);
    check_empty("t5_drain");

    // 6: pointer wrap from owner 3 back to requester 0
    do_reset();
    set_stream(3, 2, 0, 8'h30, 8'hD0, 2);
    set_stream(0, 1, 2, 8'h00, 8'hA0, 2);
    push(2, 8'h30, 8'hD0, 3);
    push(4, 8'h00, 8'hA0, 0);
    push(6, 8'h31, 8'hD1, 3);
    start_test();
    run_to(12);
    check_empty("t6_drain");

    // Variant N_REQ=2, MAX_BURST=1: rotation
    sel = 1'b1;
    do_reset();
    set_stream(0, 2, 0, 8'h00, 8'hA0, 2);
    set_stream(1, 2, 0, 8'h10, 8'hB0, 2);
    push(2, 8'h00, 8'hA0, 0);
    push(4, 8'h10, 8'hB0, 1);
    push(6, 8'h01, 8'hA1, 0);
    push(8, 8'h11, 8'hB1, 1);
    start_test();
    run_to(14);
    check_empty("v2_drain");

    // Variant: every grant is a single beat regardless of last
    do_reset();
    set_stream(1, 3, 0, 8'h10, 8'hB0, 0);
    set_stream(0, 1, 0, 8'h00, 8'hA0, 1);
    push(2, 8'h00, 8'hA0, 0);
    push(4, 8'h10, 8'hB0, 1);
    push(6, 8'h11, 8'hB1, 1);
    push(8, 8'h12, 8'hB2, 1);
    start_test();
    run_to(4);
    check("v3_busy_c4", int'(busy_m), 0);
    run_to(14);
    check_empty("v3_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
